// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and bus helpers for the interrupt controller.
package int_ctrl_pkg;

    // Vector index shown while the controller is still in its reset state.
    localparam logic [5:0] VEC_RESET = 6'd63;
    // Vector index of the non-maskable interrupt.
    localparam logic [5:0] VEC_NMI   = 6'd62;

    // Byte offsets of the registers from the block base address.
    localparam logic [15:0] OFS_IE  = 16'd0;
    localparam logic [15:0] OFS_IFG = 16'd2;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_IDLE = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Byte lanes touched by a bus write: a full word, or one byte chosen by address bit 0.
    function automatic logic [15:0] lane_mask(input logic bw, input logic a0);
        if (!bw)
            return 16'hFFFF;
        else if (!a0)
            return 16'h00FF;
        else
            return 16'hFF00;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: reports whether any input is set and the index of the highest one.
module int_prio_enc #(
    parameter int NUM_SRC = 16
) (
    input  logic [NUM_SRC-1:0] i_pend,
    output logic               o_valid,
    output logic [3:0]         o_idx
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        o_valid = |i_pend;
        o_idx   = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_pend[i])
                o_idx = 4'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched flags, enable mask, prioritised vector to the CPU
// and memory-mapped IE/IFG registers on the CPU bus.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_SRC  = 16,
    parameter int          BASE_VEC = 40,
    parameter logic [15:0] REG_BASE = 16'h0000
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               NMI_SRC,
    input  logic               INTACK,
    input  logic [15:0]        MAB,
    input  logic [15:0]        MDBout,
    input  logic               MW,
    input  logic               BW,
    output logic [15:0]        MDBin,
    output logic               INT,
    output logic               NMI,
    output logic [5:0]         IntAddrLSBs
);

    localparam logic [15:0] ADDR_IE  = REG_BASE + OFS_IE;
    localparam logic [15:0] ADDR_IFG = REG_BASE + OFS_IFG;

    logic [NUM_SRC-1:0] r_ie, r_ifg, r_irq_q;
    logic               r_nmiifg, r_nmi_q;
    logic               r_int, r_nmi;
    logic [5:0]         r_vec;
    state_t             r_state, w_state_next;

    logic               w_hit_ie, w_hit_ifg;
    logic [15:0]        w_lane, w_wdata, w_ie_wr16, w_ifg_wr16, w_rd_word;
    logic [NUM_SRC-1:0] w_ie_next, w_ifg_base, w_ifg_next;
    logic [NUM_SRC-1:0] w_set, w_ack_clr, w_pend;
    logic               w_nmi_set, w_nmi_ack_clr, w_nmiifg_next, w_ack_entry;
    logic               w_enc_valid, w_win_valid;
    logic [3:0]         w_enc_idx;
    logic [5:0]         w_win_vec, w_vec_next;
    logic               w_int_next, w_nmi_next;

    // ---------------- bus decode ----------------
    assign w_hit_ie  = (MAB[15:1] == ADDR_IE[15:1]);
    assign w_hit_ifg = (MAB[15:1] == ADDR_IFG[15:1]);
    assign w_lane    = lane_mask(BW, MAB[0]);
    // Byte writes carry their data in the low byte; replicate it so either lane can take it.
    assign w_wdata   = BW ? {MDBout[7:0], MDBout[7:0]} : MDBout;

    assign w_ie_wr16  = (16'(r_ie)  & ~w_lane) | (w_wdata & w_lane);
    assign w_ifg_wr16 = (16'(r_ifg) & ~w_lane) | (w_wdata & w_lane);

    // Unimplemented bits above NUM_SRC are dropped here, so they read back as 0.
    assign w_ie_next  = (MW && w_hit_ie)  ? w_ie_wr16[NUM_SRC-1:0]  : r_ie;
    assign w_ifg_base = (MW && w_hit_ifg) ? w_ifg_wr16[NUM_SRC-1:0] : r_ifg;

    // Read mux: zero when no register is addressed so the bus can be OR-combined.
    assign w_rd_word = w_hit_ie  ? 16'(r_ie)  :
                       w_hit_ifg ? 16'(r_ifg) : 16'h0000;
    assign MDBin     = !BW    ? w_rd_word :
                       MAB[0] ? {8'h00, w_rd_word[15:8]} : {8'h00, w_rd_word[7:0]};

    // ---------------- flag set / clear ----------------
    assign w_set       = IRQ & ~r_irq_q;
    assign w_nmi_set   = NMI_SRC & ~r_nmi_q;
    // The clear happens only on the first INTACK cycle, using the frozen vector.
    assign w_ack_entry = (r_state == S_IDLE) && INTACK;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack_clr
            assign w_ack_clr[gi] = w_ack_entry && (r_vec == 6'(BASE_VEC + gi));
        end
    endgenerate

    assign w_nmi_ack_clr = w_ack_entry && (r_vec == VEC_NMI);

    // Clears are applied before sets so a fresh edge always survives a same-cycle clear.
    assign w_ifg_next    = (w_ifg_base & ~w_ack_clr) | w_set;
    assign w_nmiifg_next = (r_nmiifg & ~w_nmi_ack_clr) | w_nmi_set;

    // ---------------- priority ----------------
    assign w_pend = r_ifg & r_ie;

    int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .i_pend  (w_pend),
        .o_valid (w_enc_valid),
        .o_idx   (w_enc_idx)
    );

    assign w_win_valid = r_nmiifg | w_enc_valid;
    assign w_win_vec   = r_nmiifg ? VEC_NMI : (6'(BASE_VEC) + 6'(w_enc_idx));

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge MCLK) begin
        if (reset)
            r_state <= S_RST;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: any INTACK enters S_ACK; leaving S_ACK lands in S_IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:   if (INTACK) w_state_next = S_ACK;
            S_IDLE:  if (INTACK) w_state_next = S_ACK;
            S_ACK:   if (!INTACK) w_state_next = S_IDLE;
            default: w_state_next = S_RST;
        endcase
    end

    // Output logic: request lines follow the flags except in S_RST; the vector moves only in S_IDLE.
    always_comb begin
        w_int_next = |w_pend;
        w_nmi_next = r_nmiifg;
        w_vec_next = r_vec;
        case (r_state)
            S_RST: begin
                w_int_next = 1'b0;
                w_nmi_next = 1'b0;
                w_vec_next = VEC_RESET;
            end
            S_IDLE: begin
                if (!INTACK && w_win_valid)
                    w_vec_next = w_win_vec;
            end
            default: ;
        endcase
    end

    // Flag, enable and edge-detect registers.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_ie     <= '0;
            r_ifg    <= '0;
            r_irq_q  <= '0;
            r_nmiifg <= 1'b0;
            r_nmi_q  <= 1'b0;
        end else begin
            r_ie     <= w_ie_next;
            r_ifg    <= w_ifg_next;
            r_irq_q  <= IRQ;
            r_nmiifg <= w_nmiifg_next;
            r_nmi_q  <= NMI_SRC;
        end
    end

    // Registered CPU request outputs.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_int <= 1'b0;
            r_nmi <= 1'b0;
            r_vec <= VEC_RESET;
        end else begin
            r_int <= w_int_next;
            r_nmi <= w_nmi_next;
            r_vec <= w_vec_next;
        end
    end

    assign INT         = r_int;
    assign NMI         = r_nmi;
    assign IntAddrLSBs = r_vec;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a register-access vector table plus hand-written interrupt sequences.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        MCLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IRQ = '0;
    logic        NMI_SRC = 1'b0;
    logic        INTACK = 1'b0;
    logic [15:0] MAB = '0;
    logic [15:0] MDBout = '0;
    logic        MW = 1'b0;
    logic        BW = 1'b0;
    logic [15:0] MDBin;
    logic        INT, NMI;
    logic [5:0]  IntAddrLSBs;

    int n_pass = 0;
    int n_tot  = 0;

    int_ctrl #(.NUM_SRC(16), .BASE_VEC(40), .REG_BASE(16'h0000)) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .IRQ         (IRQ),
        .NMI_SRC     (NMI_SRC),
        .INTACK      (INTACK),
        .MAB         (MAB),
        .MDBout      (MDBout),
        .MW          (MW),
        .BW          (BW),
        .MDBin       (MDBin),
        .INT         (INT),
        .NMI         (NMI),
        .IntAddrLSBs (IntAddrLSBs)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic        wr;    // 1 = write data, 0 = read and compare with data
        logic        bw;
        logic [15:0] mab;
        logic [15:0] data;
    } acc_t;

    acc_t tbl[20];

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else begin
            n_pass++;
            $display("check %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB = addr; MDBout = data; BW = bw; MW = 1'b1;
        step();
        MW = 1'b0; BW = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [15:0] addr, input logic bw,
                         input logic [15:0] exp);
        MAB = addr; BW = bw; MW = 1'b0;
        #1;
        chk(name, MDBin, exp);
        BW = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Register-access vectors: IE at 0, IFG at 2.
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h1234};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h1234};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0034};
        tbl[3]  = '{1'b0, 1'b1, 16'h0001, 16'h0012};
        tbl[4]  = '{1'b1, 1'b1, 16'h0001, 16'h00AB};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'hAB34};
        tbl[6]  = '{1'b1, 1'b1, 16'h0000, 16'h00CD};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'hABCD};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 16'h0002, 16'h8001};
        tbl[11] = '{1'b0, 1'b0, 16'h0002, 16'h8001};
        tbl[12] = '{1'b0, 1'b1, 16'h0003, 16'h0080};
        tbl[13] = '{1'b0, 1'b0, 16'h0004, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 16'h1000, 16'h0000};
        tbl[15] = '{1'b1, 1'b0, 16'h0004, 16'hFFFF};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 16'h0002, 16'h8001};
        tbl[18] = '{1'b1, 1'b0, 16'h0002, 16'h0000};
        tbl[19] = '{1'b0, 1'b0, 16'h0002, 16'h0000};

        // Reset for three cycles, no INTACK.
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_vec", 16'(IntAddrLSBs), 16'd63);
        chk("rst_int", 16'(INT), 16'd0);
        chk("rst_nmi", 16'(NMI), 16'd0);
        INTACK = 1'b1; step(); INTACK = 1'b0; step();
        chk("ack_from_rst_state", 16'(dut.r_state), 16'(S_IDLE));
        chk("ack_from_rst_vec", 16'(IntAddrLSBs), 16'd63);
        rdchk("ack_from_rst_ifg", 16'h0002, 1'b0, 16'h0000);

        // Register access table.
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].wr)
                wr(tbl[i].mab, tbl[i].data, tbl[i].bw);
            else
                rdchk($sformatf("tbl%0d", i), tbl[i].mab, tbl[i].bw, tbl[i].data);
        end
        step();

        // Single source: IE bit 3, IRQ[3] edge.
        wr(16'h0000, 16'h0008, 1'b0);
        IRQ = 16'h0008; step(); IRQ = '0;
        rdchk("irq3_ifg", 16'h0002, 1'b0, 16'h0008);
        chk("irq3_int_early", 16'(INT), 16'd0);
        step();
        chk("irq3_int", 16'(INT), 16'd1);
        chk("irq3_vec", 16'(IntAddrLSBs), 16'd43);
        INTACK = 1'b1; step(); step(); INTACK = 1'b0;
        rdchk("irq3_ack_ifg", 16'h0002, 1'b0, 16'h0000);
        chk("irq3_ack_int", 16'(INT), 16'd0);
        step();

        // Two sources together: highest index first.
        wr(16'h0000, 16'hFFFF, 1'b0);
        IRQ = 16'h0204; step(); IRQ = '0; step();
        chk("dual_vec49", 16'(IntAddrLSBs), 16'd49);
        chk("dual_int", 16'(INT), 16'd1);
        INTACK = 1'b1; step(); INTACK = 1'b0; step(); step();
        chk("dual_vec42", 16'(IntAddrLSBs), 16'd42);
        chk("dual_int_still", 16'(INT), 16'd1);
        INTACK = 1'b1; step(); INTACK = 1'b0; step();
        chk("dual_int_done", 16'(INT), 16'd0);
        rdchk("dual_ifg_done", 16'h0002, 1'b0, 16'h0000);

        // NMI preempts a pending maskable source.
        IRQ = 16'h0020; step(); IRQ = '0; step();
        chk("nmi_pre_vec45", 16'(IntAddrLSBs), 16'd45);
        NMI_SRC = 1'b1; step(); NMI_SRC = 1'b0; step();
        chk("nmi_out", 16'(NMI), 16'd1);
        chk("nmi_vec62", 16'(IntAddrLSBs), 16'd62);
        INTACK = 1'b1; step(); INTACK = 1'b0; step(); step();
        chk("nmi_cleared", 16'(NMI), 16'd0);
        chk("nmi_back_vec45", 16'(IntAddrLSBs), 16'd45);
        chk("nmi_back_int", 16'(INT), 16'd1);
        rdchk("nmi_ifg5_kept", 16'h0002, 1'b0, 16'h0020);

        // New edge on the same cycle as the ack that clears it: the set wins.
        wr(16'h0002, 16'h0000, 1'b0);
        IRQ = 16'h0010; step(); IRQ = '0; step();
        chk("race_vec44", 16'(IntAddrLSBs), 16'd44);
        IRQ = 16'h0010; INTACK = 1'b1; step(); IRQ = '0; INTACK = 1'b0;
        rdchk("race_ifg4_set", 16'h0002, 1'b0, 16'h0010);
        step();
        wr(16'h0002, 16'h8010, 1'b0);
        wr(16'h0003, 16'h0000, 1'b1);
        rdchk("byte_clr_hi", 16'h0002, 1'b0, 16'h0010);
        rdchk("byte_rd_lo", 16'h0002, 1'b1, 16'h0010);

        // Reset while in S_ACK with flags pending.
        wr(16'h0002, 16'h00FF, 1'b0);
        step();
        chk("prerst_vec47", 16'(IntAddrLSBs), 16'd47);
        INTACK = 1'b1; step();
        rdchk("prerst_ifg", 16'h0002, 1'b0, 16'h007F);
        reset = 1'b1; step(); reset = 1'b0; INTACK = 1'b0;
        rdchk("midrst_ifg", 16'h0002, 1'b0, 16'h0000);
        rdchk("midrst_ie", 16'h0000, 1'b0, 16'h0000);
        chk("midrst_vec", 16'(IntAddrLSBs), 16'd63);
        chk("midrst_int", 16'(INT), 16'd0);
        chk("midrst_nmi", 16'(NMI), 16'd0);
        chk("midrst_state", 16'(dut.r_state), 16'(S_RST));
        rdchk("nonreg_read", 16'h0100, 1'b0, 16'h0000);

        // In S_RST flags accumulate but requests stay quiet.
        wr(16'h0000, 16'hFFFF, 1'b0);
        IRQ = 16'h0002; step(); IRQ = '0; step(); step();
        chk("rst_hold_int", 16'(INT), 16'd0);
        chk("rst_hold_vec", 16'(IntAddrLSBs), 16'd63);
        rdchk("rst_accum_ifg", 16'h0002, 1'b0, 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller that drives the CPU's interrupt request interface (NMI, INT, IntAddrLSBs) and consumes its INTACK. It latches peripheral interrupt edges into flag registers, masks them with an enable register, and presents the highest-priority vector index to the CPU. IE and IFG are memory-mapped and respond on the CPU memory bus (MAB/MDBout/MW/BW in, MDBin out) alongside the other memory responders.

Parameters:
NUM_SRC, 16, number of maskable sources (1..16)
BASE_VEC, 40, vector index of source 0; source i uses BASE_VEC+i; BASE_VEC+NUM_SRC must be <= 62
REG_BASE, 16'h0000, word-aligned byte address of IE; IFG is at REG_BASE+2

Ports:
MCLK  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
IRQ  input  NUM_SRC  peripheral requests, rising-edge sensitive, synchronous to MCLK
NMI_SRC  input  1  non-maskable request, rising-edge sensitive
INTACK  input  1  CPU acknowledge, high while the CPU fetches the vector
MAB  input  16  memory address bus
MDBout  input  16  CPU write data
MW  input  1  write strobe, 1 = write this cycle
BW  input  1  byte access, 1 = byte
MDBin  output  16  read data for IE/IFG; 16'h0000 when MAB does not hit a register (OR-able bus)
INT  output  1  maskable request pending
NMI  output  1  NMI pending
IntAddrLSBs  output  6  vector index presented to CPU

Behaviour:
- Clock MCLK, reset synchronous active-high. Reset values: IE=0, IFG=0, NMIIFG=0, edge-detect flops=0, INT=0, NMI=0, IntAddrLSBs=63, state=S_RST. Reset mid-operation discards all pending flags and returns to S_RST.
- Edge detect: irq_q <= IRQ each cycle; set_vec = IRQ & ~irq_q. IFG bit set on the edge where IRQ is sampled high and irq_q is low. NMI_SRC identical into NMIIFG.
- INT, NMI, IntAddrLSBs are registered. IRQ sampled high at edge k -> IFG set after edge k -> INT/IntAddrLSBs valid after edge k+1 (2-cycle latency).
- INT = |(IFG & IE) (registered). NMI = NMIIFG (registered, unmaskable).
- Priority: NMI (62) over all maskable sources; among maskable, highest index wins.
- States:
  S_RST: IntAddrLSBs held at 63, INT=NMI=0 regardless of flags; flags still accumulate. On INTACK sampled high -> S_ACK, nothing cleared.
  S_IDLE: IntAddrLSBs updated each cycle to the winning vector; holds its previous value when nothing is pending. On INTACK sampled high -> S_ACK.
  S_ACK: IntAddrLSBs frozen. On the entry edge (first INTACK-high cycle) clear the flag of the frozen vector: NMIIFG if 62, IFG[v-BASE_VEC] if in range, nothing if 63. Stay while INTACK high; INTACK low -> S_IDLE.
- Set/clear same cycle on the same bit (hardware edge vs. ack clear or software write): set wins.
- INTACK with nothing pending: no flag cleared, no error.
- Register access when MAB[15:1] == address[15:1]: word write (BW=0) loads all 16 bits; byte write (BW=1) loads the low byte if MAB[0]=0, else the high byte. Bits >= NUM_SRC read 0 and ignore writes. Reads combinational: word returns the register; byte returns the addressed byte zero-extended.
- Software may set or clear IFG bits; a software-set bit behaves as a hardware request.

Decomposition:
- Package int_ctrl_pkg: VEC_RESET=6'd63, VEC_NMI=6'd62, offsets OFS_IE=0 and OFS_IFG=2, state encoding S_RST/S_IDLE/S_ACK.
- One sub-module: int_prio_enc (combinational, NUM_SRC-wide masked-pending in -> valid and index of highest set bit).

Test Plan:
- Reset 3 cycles, no INTACK -> IntAddrLSBs=63, INT=0, NMI=0; pulse INTACK 1 cycle -> state S_IDLE, no flags change.
- Word-write IE=16'h0008 at REG_BASE, pulse IRQ[3] -> IFG reads 16'h0008 one cycle later; INT=1, IntAddrLSBs=43 two cycles after the IRQ edge; INTACK 2 cycles -> IFG=0, INT=0 after ack.
- IE=16'hFFFF; pulse IRQ[2] and IRQ[9] together -> vector 49; after ack, vector 42 and INT stays 1; after second ack, INT=0.
- IRQ[5] pending and enabled, then NMI_SRC edge -> NMI=1, IntAddrLSBs=62; ack clears only NMIIFG; vector then returns to 45.
- IRQ[4] edge in the same cycle as the ack that clears IRQ[4] -> IFG[4] remains 1. Byte write 8'h00 at REG_BASE+3 -> IFG high byte cleared, low byte unchanged.
- Flags pending, reset asserted mid-S_ACK -> all flags 0, IntAddrLSBs=63, S_RST. Read of a non-register address -> MDBin=0.
